// File: rtl/io_map_pkg.sv
// Shared definitions for the I/O strobe sequencer: FSM states and requester IDs.
package io_map_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    localparam logic REQ_MAIN = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/io_latch_bank.sv
// Bank of preset-able output latches; one shared data bus, one enable per latch.
module io_latch_bank #(
    parameter int            NLATCH     = 4,
    parameter int            DW         = 8,
    parameter logic [DW-1:0] PRESET_VAL = {DW{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   preset,
    input  logic [NLATCH-1:0]      ce,
    input  logic [DW-1:0]          d,
    output logic [NLATCH*DW-1:0]   q
);

    logic [NLATCH-1:0][DW-1:0] mem_q;

    // Preset beats a same-cycle write: the strobed data is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= {NLATCH{PRESET_VAL}};
        end else if (preset) begin
            mem_q <= {NLATCH{PRESET_VAL}};
        end else begin
            for (int i = 0; i < NLATCH; i++) begin
                if (ce[i]) mem_q[i] <= d;
            end
        end
    end

    assign q = mem_q;

endmodule

// File: rtl/io_strobe_sequencer.sv
// Two-requester round-robin arbiter and setup/strobe/hold sequencer driving
// a shared latch bank with a 4-phase req/ack handshake per requester.
module io_strobe_sequencer
    import io_map_pkg::*;
#(
    parameter int            NLATCH     = 4,
    parameter int            AW         = 2,
    parameter int            DW         = 8,
    parameter int            SETUP_CYC  = 2,
    parameter int            HOLD_CYC   = 1,
    parameter logic [DW-1:0] PRESET_VAL = {DW{1'b1}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        data0,
    input  logic [DW-1:0]        data1,
    output logic                 ack0,
    output logic                 ack1,
    input  logic                 preset,
    output logic [NLATCH*DW-1:0] latch_q,
    output logic [NLATCH-1:0]    latch_ce,
    output logic                 busy
);

    localparam int CNT_MAX = max2(SETUP_CYC, HOLD_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
    localparam logic [AW:0]   NL       = (AW + 1)'(NLATCH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            req_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= REQ_MAIN;
            last_q  <= REQ_AUX;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign req_gnt = gnt_q ? req1 : req0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last time wins.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    last_d  = gnt_d;
                    addr_d  = gnt_d ? addr1 : addr0;
                    data_d  = gnt_d ? data1 : data0;
                    cnt_d   = SETUP_LD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) state_d = ST_STROBE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_STROBE: begin
                cnt_d   = HOLD_LD;
                state_d = (HOLD_CYC == 0) ? ST_ACK : ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ACK: begin
                if (!req_gnt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range addresses still run the full sequence but strobe nothing.
    always_comb begin
        latch_ce = '0;
        if (state_q == ST_STROBE && {1'b0, addr_q} < NL)
            latch_ce = NLATCH'(1) << addr_q;
    end

    assign ack0 = (state_q == ST_ACK) && (gnt_q == REQ_MAIN);
    assign ack1 = (state_q == ST_ACK) && (gnt_q == REQ_AUX);
    assign busy = (state_q != ST_IDLE);

    io_latch_bank #(
        .NLATCH     (NLATCH),
        .DW         (DW),
        .PRESET_VAL (PRESET_VAL)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .preset (preset),
        .ce     (latch_ce),
        .d      (data_q),
        .q      (latch_q)
    );

endmodule

// File: tb/tb_io_strobe_sequencer.sv
// Directed plus randomized bench for io_strobe_sequencer (3 latches, S=2, H=1).
module tb_io_strobe_sequencer;

    localparam int NLATCH = 3;
    localparam int AW     = 2;
    localparam int DW     = 8;
    localparam int S      = 2;
    localparam int H      = 1;
    localparam int LAT    = S + H + 2;
    localparam int STB    = S + 1;

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, preset;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic ack0, ack1, busy;
    logic [NLATCH*DW-1:0] latch_q;
    logic [NLATCH-1:0]    latch_ce;

    int errors = 0;
    int checks = 0;
    int multi_ce = 0;
    int ce_in_reset = 0;

    logic [7:0] m [NLATCH];
    int last_srv;

    always #5 clk = ~clk;

    io_strobe_sequencer #(
        .NLATCH(NLATCH), .AW(AW), .DW(DW), .SETUP_CYC(S), .HOLD_CYC(H),
        .PRESET_VAL(8'hFF)
    ) dut (
        .clk(clk), .reset(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
        .preset(preset), .latch_q(latch_q), .latch_ce(latch_ce), .busy(busy)
    );

    always @(negedge clk) begin
        if ($countones(latch_ce) > 1) multi_ce++;
        if (rst && latch_ce != '0) ce_in_reset++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_q();
        return 64'({m[2], m[1], m[0]});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLATCH; i++) m[i] = 8'hFF;
        last_srv = 1;
    endtask

    // Serve requester r whose req is already high; DUT must be IDLE now.
    // pcyc: cycle (0 = grant cycle) in which preset pulses, -1 for none.
    task automatic serve(input int r, input logic [1:0] a, input logic [7:0] d, input int pcyc);
        int lat = -1;
        int ce_cyc = -1;
        logic [NLATCH-1:0] ce_val = '0;
        logic [NLATCH-1:0] exp_ce;
        logic [63:0] q_at_write = '0;
        logic ackr;
        exp_ce = (int'(a) < NLATCH) ? NLATCH'(1) << a : '0;
        // Write lands at the end of the strobe cycle unless a preset is there or later.
        if (pcyc >= 0) for (int i = 0; i < NLATCH; i++) m[i] = 8'hFF;
        if (int'(a) < NLATCH && (pcyc < 0 || pcyc < STB)) m[a] = d;
        if (pcyc >= STB) for (int i = 0; i < NLATCH; i++) m[i] = 8'hFF;
        last_srv = r;
        for (int t = 0; t < 40; t++) begin
            preset = (t == pcyc);
            tick();
            if (latch_ce != '0 && ce_cyc < 0) begin
                ce_cyc = t + 1;
                ce_val = latch_ce;
            end
            if (t + 1 == STB + 1) q_at_write = 64'(latch_q);
            ackr = (r == 0) ? ack0 : ack1;
            if (ackr) begin
                lat = t + 1;
                break;
            end
        end
        preset = 1'b0;
        chk($sformatf("ack_latency_r%0d", r), 64'(lat), 64'(LAT));
        chk("ce_value", 64'(ce_val), 64'(exp_ce));
        chk("ce_cycle", 64'(ce_cyc), (exp_ce != '0) ? 64'(STB) : 64'hFFFF_FFFF_FFFF_FFFF);
        if (pcyc != STB + 1) chk("q_after_strobe", q_at_write, model_q());
        chk("q_after_ack", 64'(latch_q), model_q());
        chk("other_ack_low", 64'((r == 0) ? ack1 : ack0), 64'(0));
        tick();
        chk("ack_held", 64'((r == 0) ? ack0 : ack1), 64'(1));
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        chk("ack_dropped", 64'((r == 0) ? ack0 : ack1), 64'(0));
    endtask

    initial begin
        int w, mode, pc;
        logic [1:0] a0, a1;
        logic [7:0] d0, d1;
        rst = 1'b1; req0 = 0; req1 = 0; preset = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        model_reset();
        tick(); tick();
        chk("rst_ack0", 64'(ack0), 64'(0));
        chk("rst_ack1", 64'(ack1), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ce", 64'(latch_ce), 64'(0));
        chk("rst_q", 64'(latch_q), model_q());
        rst = 1'b0;
        tick();

        // Single write: latch 2 <= 5A
        addr0 = 2'd2; data0 = 8'h5A; req0 = 1'b1;
        serve(0, 2'd2, 8'h5A, -1);

        // Reset in the middle of SETUP aborts with no ack and no strobe
        addr1 = 2'd0; data1 = 8'h11; req1 = 1'b1;
        tick();
        chk("busy_in_setup", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        model_reset();
        chk("abort_ack1", 64'(ack1), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_q", 64'(latch_q), model_q());
        req1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("idle_after_abort", 64'(busy), 64'(0));
        chk("no_ack_after_abort", 64'({ack0, ack1}), 64'(0));
        chk("q_after_abort", 64'(latch_q), model_q());

        // Tie from reset: req0 first, req1 waits and follows
        addr0 = 2'd0; data0 = 8'hA0; addr1 = 2'd1; data1 = 8'hB1;
        req0 = 1'b1; req1 = 1'b1;
        serve(0, 2'd0, 8'hA0, -1);
        serve(1, 2'd1, 8'hB1, -1);
        // Repeat tie: rotation decides
        addr0 = 2'd2; data0 = 8'hC2; addr1 = 2'd0; data1 = 8'hD0;
        req0 = 1'b1; req1 = 1'b1;
        w = (last_srv == 0) ? 1 : 0;
        serve(w, w ? 2'd0 : 2'd2, w ? 8'hD0 : 8'hC2, -1);
        serve(1 - w, w ? 2'd2 : 2'd0, w ? 8'hC2 : 8'hD0, -1);

        // Preset in the strobe cycle beats the write
        addr1 = 2'd1; data1 = 8'h3C; req1 = 1'b1;
        serve(1, 2'd1, 8'h3C, STB);

        // Out-of-range address: no strobe, still acked
        addr0 = 2'd2; data0 = 8'h77; req0 = 1'b1;
        serve(0, 2'd2, 8'h77, -1);
        addr0 = 2'd3; data0 = 8'hEE; req0 = 1'b1;
        serve(0, 2'd3, 8'hEE, -1);

        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            a0 = 2'($urandom_range(0, 3)); a1 = 2'($urandom_range(0, 3));
            d0 = 8'($urandom); d1 = 8'($urandom);
            pc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            addr0 = a0; data0 = d0; addr1 = a1; data1 = d1;
            if (mode == 0) begin
                req0 = 1'b1;
                serve(0, a0, d0, pc);
            end else if (mode == 1) begin
                req1 = 1'b1;
                serve(1, a1, d1, pc);
            end else begin
                req0 = 1'b1; req1 = 1'b1;
                w = (last_srv == 0) ? 1 : 0;
                serve(w, w ? a1 : a0, w ? d1 : d0, pc);
                serve(1 - w, w ? a0 : a1, w ? d0 : d1, -1);
            end
        end

        chk("ce_onehot", 64'(multi_ce), 64'(0));
        chk("ce_during_reset", 64'(ce_in_reset), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
